alu_rr_sched: RTL and testbench

//  Round-robin scheduler sharing one 4-bit ALU (ops selected by m,s1,s0) between two requesters.

---
 rtl/alu_rr_sched.sv | 129 ++++++++++++
 tb/tb_alu_rr_sched.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_sched.sv
// Round-robin arbiter sharing one external WIDTH-bit ALU between two valid/ready requesters.
// Optional grant counters are enabled by defining ALU_RR_SCHED_STATS_EN.
module alu_rr_sched #(
    parameter int WIDTH  = 4,
    parameter int STAT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zero,
    output logic             rsp_ovf,
    output logic             alu_m,
    output logic             alu_s1,
    output logic             alu_s0,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
`ifdef ALU_RR_SCHED_STATS_EN
    output logic [STAT_W-1:0] gnt0_cnt,
    output logic [STAT_W-1:0] gnt1_cnt,
`endif
    input  logic [WIDTH-1:0] alu_out
);

    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, HOLD = 2'd2} state_t;

    state_t           state, state_nxt;
    logic             last_gnt, gnt, accept, ovf_nxt;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q, data_q;
    logic             id_q, rsp_id_q, zero_q, ovf_q;

    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        gnt        = (req0_valid && req1_valid) ? ~last_gnt : req1_valid;
        case (state)
            IDLE: if ((req0_valid || req1_valid) && !rst) begin
                accept     = 1'b1;
                req0_ready = ~gnt;
                req1_ready = gnt;
                state_nxt  = EXEC;
            end
            EXEC:    state_nxt = HOLD;
            HOLD:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A+B overflows exactly when A exceeds the headroom left by B, i.e. A > ~B.
    always_comb begin
        ovf_nxt = 1'b0;
        case (op_q)
            3'b100:  ovf_nxt = (a_q == '0);
            3'b101:  ovf_nxt = (a_q > ~b_q);
            3'b110:  ovf_nxt = (b_q > a_q);
            3'b111:  ovf_nxt = (a_q == '1);
            default: ovf_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            id_q     <= 1'b0;
            rsp_id_q <= 1'b0;
            data_q   <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                last_gnt <= gnt;
                id_q     <= gnt;
                op_q     <= gnt ? req1_op : req0_op;
                a_q      <= gnt ? req1_a  : req0_a;
                b_q      <= gnt ? req1_b  : req0_b;
            end
            if (state == EXEC) begin
                data_q   <= alu_out;
                zero_q   <= (alu_out == '0);
                ovf_q    <= ovf_nxt;
                rsp_id_q <= id_q;
            end
        end
    end

`ifdef ALU_RR_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt0_cnt <= '0;
            gnt1_cnt <= '0;
        end else if (accept) begin
            if (!gnt && gnt0_cnt != '1) gnt0_cnt <= gnt0_cnt + 1'b1;
            if (gnt && gnt1_cnt != '1)  gnt1_cnt <= gnt1_cnt + 1'b1;
        end
    end
`endif

    assign rsp_valid = (state == HOLD);
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = data_q;
    assign rsp_zero  = zero_q;
    assign rsp_ovf   = ovf_q;
    assign alu_m     = op_q[2];
    assign alu_s1    = op_q[1];
    assign alu_s0    = op_q[0];
    assign alu_a     = a_q;
    assign alu_b     = b_q;

endmodule

// File: tb/tb_alu_rr_sched.sv
// Directed bench for alu_rr_sched: behavioural ALU, scoreboard of expected responses, immediate asserts.
module tb_alu_rr_sched;

    logic       clk, rst;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [2:0] req0_op, req1_op;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_ovf;
    logic [3:0] rsp_data, alu_a, alu_b, alu_out;
    logic       alu_m, alu_s1, alu_s0;
`ifdef ALU_RR_SCHED_STATS_EN
    logic [7:0] gnt0_cnt, gnt1_cnt;
`endif

    alu_rr_sched #(.WIDTH(4), .STAT_W(8)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_ovf(rsp_ovf),
        .alu_m(alu_m), .alu_s1(alu_s1), .alu_s0(alu_s0), .alu_a(alu_a), .alu_b(alu_b),
`ifdef ALU_RR_SCHED_STATS_EN
        .gnt0_cnt(gnt0_cnt), .gnt1_cnt(gnt1_cnt),
`endif
        .alu_out(alu_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU stand-in.
    always_comb begin
        alu_out = 4'h0;
        case ({alu_m, alu_s1, alu_s0})
            3'b000: alu_out = ~alu_a;
            3'b001: alu_out = alu_a & alu_b;
            3'b010: alu_out = alu_a ^ alu_b;
            3'b011: alu_out = alu_a | alu_b;
            3'b100: alu_out = alu_a - 4'd1;
            3'b101: alu_out = alu_a + alu_b;
            3'b110: alu_out = alu_a - alu_b;
            default: alu_out = alu_a + 4'd1;
        endcase
    end

    typedef struct {
        logic       id;
        logic [3:0] data;
        logic       zero;
        logic       ovf;
    } exp_t;

    exp_t sb[$];
    bit   gnt_log[$];
    int   checks = 0;
    int   failures = 0;
    logic [3:0] last_data;
    logic [3:0] hold_data;
    logic [3:0] sweep_exp [8];

    function automatic exp_t ref_op(input logic id, input logic [2:0] op,
                                    input logic [3:0] a, input logic [3:0] b);
        exp_t e;
        int   r, ai, bi;
        ai = int'(a);
        bi = int'(b);
        e.ovf = 1'b0;
        case (op)
            3'd0: r = int'(~a);
            3'd1: r = int'(a & b);
            3'd2: r = int'(a ^ b);
            3'd3: r = int'(a | b);
            3'd4: begin r = ai - 1;  e.ovf = (ai == 0);   end
            3'd5: begin r = ai + bi; e.ovf = (r > 15);    end
            3'd6: begin r = ai - bi; e.ovf = (bi > ai);   end
            default: begin r = ai + 1; e.ovf = (ai == 15); end
        endcase
        e.id   = id;
        e.data = 4'(r & 15);
        e.zero = ((r & 15) == 0);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Handshake monitor: pushes expectations on accept, pops and compares on response.
    task automatic mon();
        exp_t e;
        if (!rst) begin
            if (req0_ready || req1_ready) chk("one_ready", {31'b0, req0_ready & req1_ready}, 0);
            if (req0_valid && req0_ready) begin
                sb.push_back(ref_op(1'b0, req0_op, req0_a, req0_b));
                gnt_log.push_back(1'b0);
            end
            if (req1_valid && req1_ready) begin
                sb.push_back(ref_op(1'b1, req1_op, req1_a, req1_b));
                gnt_log.push_back(1'b1);
            end
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) chk("sb_unexpected_rsp", 1, 0);
                else begin
                    e = sb.pop_front();
                    chk("rsp_id",   {31'b0, rsp_id},   {31'b0, e.id});
                    chk("rsp_data", {28'b0, rsp_data}, {28'b0, e.data});
                    chk("rsp_zero", {31'b0, rsp_zero}, {31'b0, e.zero});
                    chk("rsp_ovf",  {31'b0, rsp_ovf},  {31'b0, e.ovf});
                end
            end
        end
    endtask

    task automatic edge_neg(); @(negedge clk); mon(); endtask
    task automatic edge_pos(); @(posedge clk); #1; endtask
    task automatic step(); edge_neg(); edge_pos(); endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        sb.delete();
        gnt_log.delete();
    endtask

    task automatic run_op(input bit who, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        bit got;
        if (!who) begin req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; end
        else      begin req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; end
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            edge_neg();
            got = who ? req1_ready : req0_ready;
            edge_pos();
        end
        chk("accept_timeout", {31'b0, got}, 1);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            edge_neg();
            if (rsp_valid) begin got = 1'b1; last_data = rsp_data; end
            edge_pos();
        end
        chk("rsp_timeout", {31'b0, got}, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        sweep_exp = '{4'h5, 4'h2, 4'hC, 4'hE, 4'h9, 4'h0, 4'h4, 4'hB};
        rst = 1'b1; rsp_ready = 1'b0; last_data = '0; hold_data = '0;
        req0_valid = 1'b1; req0_op = '0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b1; req1_op = '0; req1_a = '0; req1_b = '0;

        // 1: reset; valids high while rst is held must not be acknowledged
        edge_pos();
        edge_neg();
        chk("rst_req0_ready", {31'b0, req0_ready}, 0);
        chk("rst_req1_ready", {31'b0, req1_ready}, 0);
        edge_pos();
        rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        edge_neg();
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 0);
        chk("rst_rsp_data",  {28'b0, rsp_data}, 0);
        chk("rst_rsp_flags", {29'b0, rsp_id, rsp_zero, rsp_ovf}, 0);
        chk("rst_alu_sel",   {29'b0, alu_m, alu_s1, alu_s0}, 0);
        chk("rst_alu_ab",    {24'b0, alu_a, alu_b}, 0);
        chk("idle_no_ready", {30'b0, req0_ready, req1_ready}, 0);
`ifdef ALU_RR_SCHED_STATS_EN
        chk("rst_cnts", {16'b0, gnt0_cnt, gnt1_cnt}, 0);
`endif
        edge_pos();

        // 2: single op 9+8, latency 2
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_op = 3'b101; req0_a = 4'h9; req0_b = 4'h8;
        edge_neg();
        chk("single_ready_T", {31'b0, req0_ready}, 1);
        edge_pos();
        req0_valid = 1'b0;
        edge_neg();
        chk("single_valid_T1", {31'b0, rsp_valid}, 0);
        chk("single_alu_drv",  {21'b0, alu_m, alu_s1, alu_s0, alu_a, alu_b}, {21'b0, 3'b101, 4'h9, 4'h8});
        edge_pos();
        edge_neg();
        chk("single_valid_T2", {31'b0, rsp_valid}, 1);
        chk("single_fields",   {25'b0, rsp_id, rsp_zero, rsp_ovf, rsp_data}, {25'b0, 3'b001, 4'h1});
        edge_pos();
        step();
        chk("single_sb_empty", sb.size(), 0);

        // 3: contention, alternating grants
        do_reset();
        req0_valid = 1'b1; req0_op = 3'b111; req0_a = 4'hF; req0_b = 4'h0;
        req1_valid = 1'b1; req1_op = 3'b110; req1_a = 4'h3; req1_b = 4'h5;
        for (int i = 0; i < 12; i++) begin
            edge_neg();
            if (rsp_valid) begin
                if (rsp_id) chk("cont_rsp1", {26'b0, rsp_zero, rsp_ovf, rsp_data}, {26'b0, 2'b01, 4'hE});
                else        chk("cont_rsp0", {26'b0, rsp_zero, rsp_ovf, rsp_data}, {26'b0, 2'b11, 4'h0});
            end
            edge_pos();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("cont_gnt_count", gnt_log.size(), 4);
        for (int i = 0; i < 4 && i < gnt_log.size(); i++)
            chk("cont_gnt_order", {31'b0, gnt_log[i]}, i % 2);
        chk("cont_sb_empty", sb.size(), 0);

        // 4: backpressure in HOLD
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_op = 3'b000; req0_a = 4'h5; req0_b = 4'h0;
        req1_valid = 1'b1; req1_op = 3'b011; req1_a = 4'h3; req1_b = 4'h4;
        edge_neg();
        chk("bp_accept0", {30'b0, req0_ready, req1_ready}, 2'b10);
        edge_pos();
        edge_neg();
        chk("bp_exec_noready", {30'b0, req0_ready, req1_ready}, 0);
        edge_pos();
        for (int i = 0; i < 5; i++) begin
            edge_neg();
            chk("bp_hold_valid",   {31'b0, rsp_valid}, 1);
            chk("bp_hold_noready", {30'b0, req0_ready, req1_ready}, 0);
            chk("bp_hold_data",    {27'b0, rsp_id, rsp_data}, {27'b0, 1'b0, 4'hA});
            if (i == 0) hold_data = rsp_data;
            else chk("bp_stable", {28'b0, rsp_data}, {28'b0, hold_data});
            edge_pos();
        end
        rsp_ready = 1'b1;
        step();
        edge_neg();
        chk("bp_idle_valid",  {31'b0, rsp_valid}, 0);
        chk("bp_next_accept", {30'b0, req0_ready, req1_ready}, 2'b01);
        edge_pos();
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (3) step();
        chk("bp_sb_empty", sb.size(), 0);

        // 5: reset in EXEC then in HOLD; next grant returns to req0
        req0_valid = 1'b1; req0_op = 3'b101; req0_a = 4'h1; req0_b = 4'h1;
        edge_neg();
        chk("mid_accept0", {31'b0, req0_ready}, 1);
        edge_pos();
        rst = 1'b1; req1_valid = 1'b1;
        edge_neg();
        chk("mid_rst_noready", {30'b0, req0_ready, req1_ready}, 0);
        edge_pos();
        rst = 1'b0; sb.delete();
        edge_neg();
        chk("mid_exec_valid", {31'b0, rsp_valid}, 0);
        chk("mid_exec_gnt",   {30'b0, req0_ready, req1_ready}, 2'b10);
        edge_pos();
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        step();
        edge_neg();
        chk("mid_hold_valid", {31'b0, rsp_valid}, 1);
        edge_pos();
        rst = 1'b1;
        step();
        rst = 1'b0; sb.delete();
        req0_valid = 1'b1; req1_valid = 1'b1;
        edge_neg();
        chk("mid_hold_rsp_valid", {31'b0, rsp_valid}, 0);
        chk("mid_hold_gnt",       {30'b0, req0_ready, req1_ready}, 2'b10);
        edge_pos();
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        repeat (3) step();
        chk("mid_sb_empty", sb.size(), 0);

        // 6: sweep all opcodes a=A b=6, then saturation of the grant counter
        do_reset();
        rsp_ready = 1'b1;
        for (int op = 0; op < 8; op++) begin
            run_op(1'b0, 3'(op), 4'hA, 4'h6);
            chk("sweep_data", {28'b0, last_data}, {28'b0, sweep_exp[op]});
        end
        chk("sweep_sb_empty", sb.size(), 0);
`ifdef ALU_RR_SCHED_STATS_EN
        chk("cnt_after_sweep", {24'b0, gnt0_cnt}, 8);
        for (int i = 0; i < 252; i++) run_op(1'b0, 3'b111, 4'(i), 4'h0);
        chk("cnt0_saturated", {24'b0, gnt0_cnt}, 8'hFF);
        chk("cnt1_zero",      {24'b0, gnt1_cnt}, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
